// File: rtl/cpu_pkg.sv
// Shared constants and fetch-stage state encoding for the MIPS core.
package cpu_pkg;
  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/pc_fetch_unit_stat_counter.sv
// Free-running enable counter with async active-low clear; wraps modulo 2^W.
module stat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch stage: fetch over req/ready, hold for decode,
// redirect on flush, stop on halt, and keep cycle/instruction statistics.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [XLEN-1:0]  PC,
  input  logic [XLEN-1:0]  PC_next_clk,
  input  logic             stall,
  input  logic             flush,
  input  logic [XLEN-1:0]  flush_pc,
  input  logic             halt,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ready,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic             instr_valid,
  output logic [XLEN-1:0]  instr_out,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            cyc_en, ins_en;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ins_en  = 1'b0;
    cyc_en  = (state_q != S_HALT);
    case (state_q)
      S_FETCH: begin
        // Flush beats a same-cycle response; the returned word is dropped.
        if (flush)           pc_d = flush_pc;
        else if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (flush) begin
          pc_d    = flush_pc;
          state_d = S_FETCH;
        end else if (!stall) begin
          ins_en = 1'b1;
          if (halt) state_d = S_HALT;
          else begin
            pc_d    = PC_next_clk;
            state_d = S_FETCH;
          end
        end
      end
      S_HALT:  ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  stat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk(clk), .rst_n(rst_n), .en(cyc_en), .cnt(cycle_cnt)
  );

  stat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk(clk), .rst_n(rst_n), .en(ins_en), .cnt(instr_cnt)
  );

  // Request is masked while reset is held so imem never sees a stale fetch.
  assign imem_req    = rst_n && (state_q == S_FETCH);
  assign PC          = pc_q;
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_HOLD);
  assign instr_out   = instr_q;
  assign halted      = (state_q == S_HALT);
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: fetch cadence, wait states, stall, flush,
// halt, async reset and counter wrap (narrow-counter instance).
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PC, PC_next_clk, flush_pc, imem_addr, imem_rdata, instr_out;
  logic        stall, flush, halt, imem_req, imem_ready, instr_valid, halted;
  logic [31:0] cycle_cnt, instr_cnt;
  logic        use_inc;
  logic [31:0] pc_next_fix;

  logic [31:0] w_pc, w_addr, w_instr;
  logic        w_req, w_valid, w_halted;
  logic [2:0]  w_cyc, w_ins;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] cyc0;

  always #5 clk = ~clk;

  assign PC_next_clk = use_inc ? PC + 32'd4 : pc_next_fix;

  pc_fetch_unit #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .PC(PC), .PC_next_clk(PC_next_clk),
    .stall(stall), .flush(flush), .flush_pc(flush_pc), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_out(instr_out),
    .halted(halted), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  pc_fetch_unit #(.RESET_PC(32'h0), .CNT_W(3)) u_wrap (
    .clk(clk), .rst_n(rst_n), .PC(w_pc), .PC_next_clk(PC_next_clk),
    .stall(stall), .flush(flush), .flush_pc(flush_pc), .halt(halt),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr_valid(w_valid), .instr_out(w_instr),
    .halted(w_halted), .cycle_cnt(w_cyc), .instr_cnt(w_ins)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; halt = 1'b0; flush_pc = '0;
    imem_ready = 1'b0; imem_rdata = '0; use_inc = 1'b1; pc_next_fix = '0;
    step(2);
    chk("rst_pc", PC, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr_out, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cyc", cycle_cnt, 0);
    chk("rst_ins", instr_cnt, 0);

    // zero-wait sequential fetch
    imem_ready = 1'b1; imem_rdata = 32'h2008_0005;
    rst_n = 1'b1;
    #1;
    chk("seq_req0", imem_req, 1);
    chk("seq_addr0", imem_addr, 0);
    for (int i = 1; i <= 6; i++) begin
      step(1);
      chk("seq_valid", instr_valid, (i % 2) == 1);
      if (i == 1) chk("seq_instr", instr_out, 32'h2008_0005);
      if (i == 2) chk("seq_addr4", imem_addr, 32'h4);
      if (i == 4) chk("seq_addr8", imem_addr, 32'h8);
    end
    chk("seq_ins3", instr_cnt, 3);
    chk("seq_cyc6", cycle_cnt, 6);

    // wait states at 0x10
    imem_ready = 1'b0; flush = 1'b1; flush_pc = 32'h10;
    step(1);
    flush = 1'b0;
    cyc0 = cycle_cnt;
    for (int i = 0; i < 3; i++) begin
      chk("ws_req", imem_req, 1);
      chk("ws_addr", imem_addr, 32'h10);
      chk("ws_valid", instr_valid, 0);
      step(1);
    end
    chk("ws_req4", imem_req, 1);
    chk("ws_addr4", imem_addr, 32'h10);
    imem_ready = 1'b1; imem_rdata = 32'hAAAA_5555;
    step(1);
    imem_ready = 1'b0;
    chk("ws_valid_up", instr_valid, 1);
    chk("ws_cyc_delta", cycle_cnt - cyc0, 4);

    // stall in hold
    use_inc = 1'b0; pc_next_fix = 32'h40; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1);
      chk("stl_pc", PC, 32'h10);
      chk("stl_instr", instr_out, 32'hAAAA_5555);
      chk("stl_valid", instr_valid, 1);
    end
    stall = 1'b0;
    step(1);
    chk("stl_pc40", PC, 32'h40);
    chk("stl_valid0", instr_valid, 0);
    chk("stl_ins4", instr_cnt, 4);

    // flush colliding with a response
    flush = 1'b1; flush_pc = 32'h100; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step(1);
    flush = 1'b0; imem_ready = 1'b0;
    chk("fl_valid", instr_valid, 0);
    chk("fl_addr", imem_addr, 32'h100);
    chk("fl_ins", instr_cnt, 4);

    // halt at 0x20
    flush = 1'b1; flush_pc = 32'h20;
    step(1);
    flush = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0000_000C;
    step(1);
    imem_ready = 1'b0;
    chk("hlt_hold", instr_valid, 1);
    halt = 1'b1;
    step(1);
    chk("hlt_halted", halted, 1);
    chk("hlt_pc", PC, 32'h20);
    chk("hlt_req", imem_req, 0);
    chk("hlt_valid", instr_valid, 0);
    chk("hlt_ins5", instr_cnt, 5);
    cyc0 = cycle_cnt;
    step(3);
    chk("hlt_cyc_frozen", cycle_cnt, cyc0);
    chk("hlt_req_late", imem_req, 0);
    flush = 1'b1; flush_pc = 32'h200;
    step(1);
    flush = 1'b0; halt = 1'b0;
    chk("hlt_flush_pc", PC, 32'h20);
    chk("hlt_flush_halted", halted, 1);

    // async reset mid-fetch at 0x80
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    flush = 1'b1; flush_pc = 32'h80;
    step(1);
    flush = 1'b0;
    step(1);
    chk("mid_addr80", imem_addr, 32'h80);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pc", PC, 0);
    chk("async_req", imem_req, 0);
    chk("async_cyc", cycle_cnt, 0);
    chk("async_ins", instr_cnt, 0);
    chk("async_halted", halted, 0);
    step(1);
    rst_n = 1'b1;
    #1;
    chk("rel_addr", imem_addr, 0);
    chk("rel_req", imem_req, 1);

    // narrow-counter wrap: 8 cycles wrap a 3-bit counter to 0
    use_inc = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h2008_0005;
    step(7);
    chk("wrap_pre", w_cyc, 7);
    step(1);
    chk("wrap_zero", w_cyc, 0);
    chk("wrap_wide", cycle_cnt, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch stage of the MIPS core.
- Holds the architectural PC and drives it to the next-PC logic.
- Fetches the instruction at that PC from instruction memory over a req/ready handshake and presents it to decode.
- Loads the next-PC value when decode accepts the instruction; also supports flush redirect, halt (syscall), and cycle/instruction statistics counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the cycle and instruction statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- PC  output  32  current PC, to the next-PC logic and to imem_addr.
- PC_next_clk  input  32  next PC from the next-PC logic, loaded on instruction accept.
- stall  input  1  hazard unit: decode cannot accept this cycle.
- flush  input  1  redirect; discard the current instruction.
- flush_pc  input  32  redirect target, valid with flush.
- halt  input  1  decoded syscall/halt for the instruction currently held.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address, equal to PC.
- imem_ready  input  1  memory has imem_rdata valid this cycle.
- imem_rdata  input  32  instruction word.
- instr_valid  output  1  instr_out holds a fetched instruction.
- instr_out  output  32  registered instruction word to decode.
- halted  output  1  core halted.
- cycle_cnt  output  CNT_W  cycles elapsed since reset, excluding halted cycles.
- instr_cnt  output  CNT_W  instructions accepted by decode.

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC, state=S_FETCH.
  - imem_req=0 during reset.
  - instr_valid=0, instr_out=0, halted=0, cycle_cnt=0, instr_cnt=0.
- States:
  - S_FETCH: imem_req=1. On a clock edge with imem_ready=1: instr_out<=imem_rdata, instr_valid<=1, go to S_HOLD. Otherwise stay; imem_req stays high and PC is unchanged.
  - S_HOLD: imem_req=0, instr_valid=1.
    - stall=1: hold everything.
    - stall=0 and halt=0: accept. PC<=PC_next_clk, instr_valid<=0, instr_cnt++, go to S_FETCH.
    - stall=0 and halt=1: accept. instr_cnt++, instr_valid<=0, PC unchanged, go to S_HALT.
  - S_HALT: halted=1, imem_req=0, instr_valid=0. Terminal until reset. flush is ignored.
- Flush (S_FETCH or S_HOLD):
  - Has priority over imem_ready, stall and halt.
  - PC<=flush_pc, instr_valid<=0, go to S_FETCH. instr_cnt is not incremented.
  - A response arriving in the same cycle is dropped.
  - imem may see imem_req stay high with a changed address; a withdrawn or redirected request is legal on this interface.
- imem_addr = PC, combinationally.
- PC[1:0]: passed through unmodified; alignment is not checked here.
- Latency: minimum 2 cycles per instruction (1 fetch + 1 hold) with zero-wait memory and no stall.
- Counters:
  - cycle_cnt increments every cycle while not in S_HALT. It freezes on the edge that enters S_HALT; that entry edge still counts.
  - Both counters wrap modulo 2^CNT_W with no saturation.
- Reset mid-fetch: the outstanding request is abandoned. After release, the first request goes to RESET_PC.

Decomposition:
- Shared package cpu_pkg:
  - fetch state encoding: S_FETCH=2'd0, S_HOLD=2'd1, S_HALT=2'd2.
  - RESET_PC default constant.
  - instruction/address width constant 32.
- One natural sub-module: stat_counter (CNT_W-bit enable counter with async active-low clear), instantiated twice.

Test Plan:
- Reset release, zero-wait imem returning 32'h2008_0005 at PC 0, stall=0, PC_next_clk=PC+4:
  - imem_addr=0, then 4, then 8.
  - instr_valid high every second cycle.
  - instr_cnt=3 after 6 cycles.
- imem_ready withheld 3 cycles at PC=0x10:
  - imem_req and imem_addr=0x10 stable for 4 cycles.
  - instr_valid rises only after ready.
  - cycle_cnt advances by 4.
- stall=1 for 2 cycles in S_HOLD with PC_next_clk=0x40:
  - PC, instr_out and instr_valid unchanged.
  - PC=0x40 one cycle after stall drops.
- flush with flush_pc=0x100 in the same cycle as imem_ready=1:
  - instr_valid stays 0, next imem_addr=0x100, instr_cnt unchanged.
- halt=1 in S_HOLD, stall=0, at PC=0x20:
  - halted=1, PC stays 0x20, imem_req=0 forever.
  - cycle_cnt frozen.
  - a later flush has no effect.
- rst_n asserted mid-S_FETCH at PC=0x80:
  - all outputs reset asynchronously, without waiting for a clock edge.
  - after release, imem_addr=RESET_PC, counters=0.
  - preload cycle_cnt near 2^32-1 (CNT_W=32) in a separate run and check it wraps to 0.
